// File: rtl/slot_reel_spinner_if.sv
// Start/credit inputs and reel/result outputs between the spinner and its surroundings.
// Handshake-free level and pulse signals; the spinner sits on the slave side.
interface slot_reel_spinner_if;
  logic       start_n;
  logic       credit_ok;
  logic [2:0] reel0;
  logic [2:0] reel1;
  logic [2:0] reel2;
  logic       spinning;
  logic       done;
  logic       win;
  logic [1:0] win_amt;
  logic       denied;

  modport master (
    output start_n, credit_ok,
    input  reel0, reel1, reel2, spinning, done, win, win_amt, denied
  );

  modport slave (
    input  start_n, credit_ok,
    output reel0, reel1, reel2, spinning, done, win, win_amt, denied
  );
endinterface

// File: rtl/slot_reel_spinner.sv
// Three-reel spin and win judge; result 1 cycle after JUDGE, i.e. (SPIN_TICKS+2*STOP_GAP)*TICK_DIV+1 after accept.
// No backpressure: presses outside IDLE are dropped, done/win/denied are single-cycle pulses.
module slot_reel_spinner #(
  parameter int TICK_DIV   = 2_500_000,
  parameter int SPIN_TICKS = 20,
  parameter int STOP_GAP   = 8
) (
  input logic               CLOCK_50,
  input logic               resetn,
  slot_reel_spinner_if.slave bus
);
  localparam int TW   = $clog2(TICK_DIV);
  localparam int LMAX = (SPIN_TICKS > STOP_GAP) ? SPIN_TICKS : STOP_GAP;
  localparam int LW   = $clog2(LMAX + 1);
  localparam logic [TW-1:0] TCNT_LAST = TW'(TICK_DIV - 1);
  localparam logic [LW-1:0] LEFT_SPIN = LW'(SPIN_TICKS);
  localparam logic [LW-1:0] LEFT_GAP  = LW'(STOP_GAP);

  typedef enum logic [2:0] {IDLE, SPIN3, SPIN2, SPIN1, JUDGE} state_t;

  typedef struct packed {
    logic [2:0] r0;
    logic [2:0] r1;
    logic [2:0] r2;
  } reels_t;

  state_t        state_q, state_d;
  logic          s1, s2, s3;
  logic          press;
  logic [8:0]    seed;
  logic [TW-1:0] tcnt;
  logic [LW-1:0] left;
  reels_t        reels;
  logic [1:0]    win_amt;
  logic          spinning, done, win, denied;
  logic          spin_st, tick, last_tick, accept, deny;
  logic [1:0]    amt;

  assign press = s3 & ~s2;

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    deny      = 1'b0;
    spin_st   = (state_q == SPIN3) || (state_q == SPIN2) || (state_q == SPIN1);
    tick      = spin_st && (tcnt == TCNT_LAST);
    last_tick = tick && (left == LW'(1));
    case (state_q)
      IDLE: begin
        if (press) begin
          if (bus.credit_ok) begin
            accept  = 1'b1;
            state_d = SPIN3;
          end else begin
            deny = 1'b1;
          end
        end
      end
      SPIN3:   if (last_tick) state_d = SPIN2;
      SPIN2:   if (last_tick) state_d = SPIN1;
      SPIN1:   if (last_tick) state_d = JUDGE;
      JUDGE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Triple beats pair; a pair is any two of the three reels matching.
  always_comb begin
    amt = 2'b00;
    if (reels.r0 == reels.r1 && reels.r1 == reels.r2)
      amt = 2'b10;
    else if (reels.r0 == reels.r1 || reels.r1 == reels.r2 || reels.r0 == reels.r2)
      amt = 2'b01;
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_q  <= IDLE;
      s1       <= 1'b1;
      s2       <= 1'b1;
      s3       <= 1'b1;
      seed     <= '0;
      tcnt     <= '0;
      left     <= '0;
      reels    <= '0;
      win_amt  <= 2'b00;
      spinning <= 1'b0;
      done     <= 1'b0;
      win      <= 1'b0;
      denied   <= 1'b0;
    end else begin
      s1       <= bus.start_n;
      s2       <= s1;
      s3       <= s2;
      seed     <= seed + 9'd1;
      state_q  <= state_d;
      spinning <= (state_d != IDLE);
      done     <= 1'b0;
      win      <= 1'b0;
      denied   <= deny;
      if (accept) begin
        reels   <= {seed[2:0], seed[5:3], seed[8:6]};
        tcnt    <= '0;
        left    <= LEFT_SPIN;
        win_amt <= 2'b00;
      end else if (spin_st) begin
        tcnt <= tick ? '0 : tcnt + TW'(1);
        if (tick) begin
          // Reels freeze left to right: reel0 only moves in SPIN3, reel1 until SPIN1.
          if (state_q == SPIN3) reels.r0 <= reels.r0 + 3'd1;
          if (state_q != SPIN1) reels.r1 <= reels.r1 + 3'd3;
          reels.r2 <= reels.r2 + 3'd5;
          left <= (last_tick && state_q != SPIN1) ? LEFT_GAP : left - LW'(1);
        end
      end
      if (state_q == JUDGE) begin
        win_amt <= amt;
        done    <= 1'b1;
        win     <= (amt != 2'b00);
      end
    end
  end

  assign bus.reel0    = reels.r0;
  assign bus.reel1    = reels.r1;
  assign bus.reel2    = reels.r2;
  assign bus.spinning = spinning;
  assign bus.done     = done;
  assign bus.win      = win;
  assign bus.win_amt  = win_amt;
  assign bus.denied   = denied;
endmodule

// File: tb/tb_slot_reel_spinner.sv
// Bench for slot_reel_spinner: seed-targeted presses, timing of spin/done/denied, reset and press filtering.
module tb_slot_reel_spinner;
  localparam int TD = 4;
  localparam int ST = 3;
  localparam int SG = 2;
  localparam int T  = ST + 2 * SG;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   edge_cnt = 0;
  int   reset_edge = 0;
  int   vectors = 0;
  int   errors = 0;

  slot_reel_spinner_if bus();

  slot_reel_spinner #(.TICK_DIV(TD), .SPIN_TICKS(ST), .STOP_GAP(SG)) dut (
    .CLOCK_50(clk),
    .resetn  (resetn),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  initial begin
    #900_000;
    $display("FAIL watchdog: time limit reached, got no finish required finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Seed value consumed by an accept when start_n drops just after edge x.
  function automatic logic [8:0] seed_for(input int x);
    return 9'((x + 2 - reset_edge) % 512);
  endfunction

  function automatic logic [2:0] spun(input logic [2:0] init, input int inc, input int n);
    return 3'((int'(init) + inc * n) % 8);
  endfunction

  function automatic logic [1:0] judge(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c);
    if (a == b && b == c) return 2'b10;
    if (a == b || b == c || a == c) return 2'b01;
    return 2'b00;
  endfunction

  task automatic launch_at_seed(input logic [8:0] s, output int x);
    int n;
    n = 0;
    repeat (2) step();
    while (seed_for(edge_cnt) != s && n < 600) begin
      step();
      n++;
    end
    vectors++;
    if (n >= 600) begin
      errors++;
      $display("FAIL seed_wait: got timeout required seed %0d", s);
    end
    x = edge_cnt;
    bus.start_n = 1'b0;
  endtask

  // Follows one accepted spin whose press dropped after edge x.
  task automatic check_spin(input int x, input bit chain, input int hold, output int d_edge);
    int a, d, e, stop;
    logic [8:0] s;
    logic [2:0] i0, i1, i2, f0, f1, f2;
    logic [1:0] amt;
    s  = seed_for(x);
    i0 = s[2:0];
    i1 = s[5:3];
    i2 = s[8:6];
    f0 = spun(i0, 1, ST);
    f1 = spun(i1, 3, ST + SG);
    f2 = spun(i2, 5, ST + 2 * SG);
    amt = judge(f0, f1, f2);
    a = x + 3;
    d = a + T * TD + 1;
    stop = chain ? d : d + 2;
    while (edge_cnt < stop) begin
      step();
      e = edge_cnt;
      if (e == a + hold) bus.start_n = 1'b1;
      if (chain && e == d - 2) bus.start_n = 1'b0;
      vectors++;
      if (bus.spinning !== (e >= a && e < d)) begin
        errors++;
        $display("FAIL spinning@A%0d: got %b required %b", e - a, bus.spinning, (e >= a && e < d));
      end
      vectors++;
      if (bus.done !== (e == d)) begin
        errors++;
        $display("FAIL done@A%0d: got %b required %b", e - a, bus.done, (e == d));
      end
      vectors++;
      if (bus.win !== (e == d && amt != 2'b00)) begin
        errors++;
        $display("FAIL win@A%0d: got %b required %b", e - a, bus.win, (e == d && amt != 2'b00));
      end
      if (e == a) begin
        vectors++;
        if ({bus.reel0, bus.reel1, bus.reel2, bus.win_amt} !== {i0, i1, i2, 2'b00}) begin
          errors++;
          $display("FAIL accept_load seed=%0d: got %0d,%0d,%0d amt=%b required %0d,%0d,%0d amt=00",
                   s, bus.reel0, bus.reel1, bus.reel2, bus.win_amt, i0, i1, i2);
        end
      end
      if (e >= d) begin
        vectors++;
        if ({bus.reel0, bus.reel1, bus.reel2, bus.win_amt} !== {f0, f1, f2, amt}) begin
          errors++;
          $display("FAIL result seed=%0d: got %0d,%0d,%0d amt=%b required %0d,%0d,%0d amt=%b",
                   s, bus.reel0, bus.reel1, bus.reel2, bus.win_amt, f0, f1, f2, amt);
        end
      end
    end
    d_edge = d;
  endtask

  task automatic spin_seed(input logic [8:0] s);
    int x, d;
    launch_at_seed(s, x);
    check_spin(x, 1'b0, $urandom_range(1, 20), d);
  endtask

  task automatic test_reset();
    bus.start_n   = 1'b1;
    bus.credit_ok = 1'b1;
    resetn = 1'b0;
    repeat (3) step();
    reset_edge = edge_cnt;
    resetn = 1'b1;
    vectors++;
    if ({bus.reel0, bus.reel1, bus.reel2, bus.win_amt, bus.spinning, bus.done, bus.win, bus.denied} !== 15'd0) begin
      errors++;
      $display("FAIL reset_state: got %0d,%0d,%0d amt=%b sp=%b d=%b w=%b dn=%b required all zero",
               bus.reel0, bus.reel1, bus.reel2, bus.win_amt, bus.spinning, bus.done, bus.win, bus.denied);
    end
  endtask

  task automatic test_pair();    spin_seed(9'd0);  endtask
  task automatic test_triple();  spin_seed(9'd32); endtask
  task automatic test_no_win();  spin_seed(9'd1);  endtask

  task automatic test_denied();
    int x, e;
    logic [8:0] prev;
    bus.credit_ok = 1'b0;
    repeat (2) step();
    prev = {bus.reel0, bus.reel1, bus.reel2};
    x = edge_cnt;
    bus.start_n = 1'b0;
    repeat (8) begin
      step();
      e = edge_cnt;
      if (e == x + 4) bus.start_n = 1'b1;
      vectors++;
      if (bus.denied !== (e == x + 3) || bus.spinning !== 1'b0) begin
        errors++;
        $display("FAIL denied@E0+%0d: got denied=%b spinning=%b required denied=%b spinning=0",
                 e - x - 1, bus.denied, bus.spinning, (e == x + 3));
      end
      vectors++;
      if ({bus.reel0, bus.reel1, bus.reel2} !== prev) begin
        errors++;
        $display("FAIL denied_reels: got %0h required %0h", {bus.reel0, bus.reel1, bus.reel2}, prev);
      end
    end
    bus.credit_ok = 1'b1;
  endtask

  task automatic test_ignore_press();
    int x, a, e, dones;
    logic [8:0] s;
    s = 9'($urandom);
    launch_at_seed(s, x);
    a = x + 3;
    dones = 0;
    while (edge_cnt < a + 120) begin
      step();
      e = edge_cnt;
      if (e == a + 3) bus.start_n = 1'b1;
      if (e == a + 15) bus.start_n = 1'b0;
      if (e == a + 115) bus.start_n = 1'b1;
      if (bus.done === 1'b1) dones++;
    end
    vectors++;
    if (dones != 1 || bus.spinning !== 1'b0) begin
      errors++;
      $display("FAIL ignore_press: got %0d done pulses spinning=%b required 1 done pulse spinning=0",
               dones, bus.spinning);
    end
    vectors++;
    if ({bus.reel0, bus.reel1, bus.reel2} !== {spun(s[2:0], 1, ST), spun(s[5:3], 3, ST + SG), spun(s[8:6], 5, T)}) begin
      errors++;
      $display("FAIL ignore_press_reels seed=%0d: got %0d,%0d,%0d", s, bus.reel0, bus.reel1, bus.reel2);
    end
  endtask

  task automatic test_reset_midspin();
    int x, a, bad;
    launch_at_seed(9'($urandom), x);
    a = x + 3;
    while (edge_cnt < a + 9) begin
      step();
      if (edge_cnt == a + 2) bus.start_n = 1'b1;
    end
    resetn = 1'b0;
    step();
    reset_edge = edge_cnt;
    resetn = 1'b1;
    vectors++;
    if ({bus.reel0, bus.reel1, bus.reel2, bus.win_amt, bus.spinning, bus.done, bus.win, bus.denied} !== 15'd0) begin
      errors++;
      $display("FAIL midspin_reset: got %0d,%0d,%0d amt=%b sp=%b d=%b w=%b dn=%b required all zero",
               bus.reel0, bus.reel1, bus.reel2, bus.win_amt, bus.spinning, bus.done, bus.win, bus.denied);
    end
    bad = 0;
    repeat (40) begin
      step();
      if (bus.done !== 1'b0 || bus.spinning !== 1'b0) bad++;
    end
    vectors++;
    if (bad != 0) begin
      errors++;
      $display("FAIL midspin_no_done: got %0d active cycles required 0", bad);
    end
    spin_seed(9'($urandom));
  endtask

  task automatic test_back_to_back();
    int x, d1, d2;
    launch_at_seed(9'($urandom), x);
    check_spin(x, 1'b1, $urandom_range(1, 20), d1);
    check_spin(d1 - 2, 1'b0, $urandom_range(1, 20), d2);
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(0, 3) == 0) test_denied();
      else spin_seed(9'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_pair();
    test_triple();
    test_no_win();
    test_denied();
    test_ignore_press();
    test_reset_midspin();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/slot_reel_spinner.md
# slot_reel_spinner

Reel-spin and win-judge stage of the slot machine. It sits directly upstream of the money controller. On an accepted pull of the start button it spins three 3-bit reels and stops them one at a time. It then scores the final symbols and emits a one-cycle `win`/`done` result with a 2-bit win amount (01 pair, 10 triple) for the credit logic to consume. `credit_ok` from the money controller gates every spin.

## Interface
- `TICK_DIV`, 2_500_000, clock cycles per reel step tick (≥2)
- `SPIN_TICKS`, 20, ticks all three reels spin before reel0 stops (≥1)
- `STOP_GAP`, 8, ticks between reel0→reel1 and reel1→reel2 stops (≥1)

- `CLOCK_50`  in  1  system clock; sole clock
- `resetn`  in  1  reset, synchronous, active-low
- `start_n`  in  1  start pushbutton, active-low, asynchronous to clock
- `credit_ok`  in  1  1 = player has credit for a spin
- `reel0`, `reel1`, `reel2`  out  3 each  current reel symbols
- `spinning`  out  1  high while FSM ≠ IDLE
- `done`  out  1  one-cycle pulse: result valid
- `win`  out  1  one-cycle pulse, coincident with `done`, when `win_amt` ≠ 00
- `win_amt`  out  2  00 none, 01 pair, 10 triple; held until next accepted spin
- `denied`  out  1  one-cycle pulse: press in IDLE with `credit_ok`=0

## Operation
- Start sync: `s1<=start_n; s2<=s1; s3<=s2`. `press = s3 & ~s2` (falling edge). Reset loads s1..s3 = 1.
- `seed`: free-running 9-bit counter, +1 every clock, wraps 511→0.
- FSM states: IDLE, SPIN3 (all reels move), SPIN2 (reel0 frozen), SPIN1 (reel0,1 frozen), JUDGE.
- IDLE + press + `credit_ok`=1 (accept):
  - reel0<=seed[2:0], reel1<=seed[5:3], reel2<=seed[8:6] (pre-increment seed value);
  - tick counter `tcnt`<=0; `left`<=SPIN_TICKS; `win_amt`<=00; state → SPIN3.
- IDLE + press + `credit_ok`=0: `denied` pulses; state stays IDLE.
- Press while not IDLE: ignored, never queued.
- Spin states:
  - `tcnt` increments each cycle and wraps at TICK_DIV-1; tick = (`tcnt`==TICK_DIV-1).
  - On a tick, moving reels step mod 8: reel0 +1, reel1 +3, reel2 +5, then `left` decrements.
  - When `left`==1 on a tick: SPIN3→SPIN2 and SPIN2→SPIN1 reload `left`<=STOP_GAP; SPIN1→JUDGE.
- Net steps per spin: reel0 SPIN_TICKS, reel1 SPIN_TICKS+STOP_GAP, reel2 SPIN_TICKS+2·STOP_GAP.
- JUDGE lasts exactly one cycle. On its exit edge:
  - `win_amt` <= 10 if all three reels are equal; else 01 if any two are equal; else 00;
  - `done`<=1; `win`<=(amt≠00); state → IDLE.
- All outputs are registered. `credit_ok` is sampled only at accept.

## Timing
- Reset (`resetn`=0 at an edge), all values set at that edge: state IDLE; reels 000; `win_amt` 00; `done`/`win`/`denied`/`spinning` 0; `seed` 0; `tcnt` 0.
- Reset mid-spin aborts the spin. No `done` is produced. Reels are forced to 000.
- Press latency: if edge E0 first samples `start_n`=0, the accept (or `denied`) happens at edge E0+2.
- Call the accept edge A.
  - `spinning` rises at A.
  - Tick k takes effect at edge A+k·TICK_DIV.
  - JUDGE is entered at A+T·TICK_DIV, where T = SPIN_TICKS+2·STOP_GAP.
  - `done` rises and `spinning` falls at A+T·TICK_DIV+1.
- `done`/`win`/`denied` are high for exactly one cycle.
- A press accepted in the first IDLE cycle after `done` is legal (back-to-back spins).
- `start_n` held low generates exactly one press.
- Bounce that produces a second falling edge during a spin is ignored.

## Test plan
All scenarios use TICK_DIV=4, SPIN_TICKS=3, STOP_GAP=2 (T=7; net steps reel0 +3, reel1 +7, reel2 +3).
- Accept with seed=9'd0 → final reels 3,7,3; `done`+`win` at A+29; `win_amt`=01.
- Accept with seed=9'd32 → reels 3,3,3; `win_amt`=10; `win` pulses once.
- Accept with seed=9'd1 → reels 4,7,3; `done` pulses, `win`=0, `win_amt`=00.
- Press with `credit_ok`=0 → `denied` pulses once at E0+2; `spinning` stays 0; reels unchanged.
- Second press during SPIN2, and `start_n` held low for 100 cycles → exactly one spin and one `done`.
- `resetn`=0 for one edge at A+10 → all outputs at reset values on the next cycle; no `done`; a new press is accepted normally afterwards.
